// File: rtl/dlx_pkg.sv
// Shared definitions for the DLX set-condition unit: condition codes,
// controller state encoding and the condition evaluation rule.
package dlx_pkg;

    // Condition codes carried by the set-condition instructions.
    localparam logic [2:0] COND_SEQ   = 3'd0;
    localparam logic [2:0] COND_SNE   = 3'd1;
    localparam logic [2:0] COND_SLT   = 3'd2;
    localparam logic [2:0] COND_SGT   = 3'd3;
    localparam logic [2:0] COND_SLE   = 3'd4;
    localparam logic [2:0] COND_SGE   = 3'd5;
    localparam logic [2:0] COND_FALSE = 3'd6;
    localparam logic [2:0] COND_TRUE  = 3'd7;

    // Controller state: waiting for a request, or scanning chunks.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Map the final ordering of the two operands onto the requested condition.
    // eq is implied when neither lt nor gt is set.
    function automatic logic eval_cond(input logic [2:0] cond,
                                       input logic       lt,
                                       input logic       gt);
        logic eq;
        logic res;
        eq  = ~lt & ~gt;
        res = 1'b0;
        case (cond)
            COND_SEQ:   res = eq;
            COND_SNE:   res = ~eq;
            COND_SLT:   res = lt;
            COND_SGT:   res = gt;
            COND_SLE:   res = lt | eq;
            COND_SGE:   res = gt | eq;
            COND_FALSE: res = 1'b0;
            COND_TRUE:  res = 1'b1;
            default:    res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dlx_chunk_cmp.sv
// Unsigned magnitude compare of one DIGIT-bit chunk of each operand.
// Equality is the absence of both lt and gt.
module dlx_chunk_cmp #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             lt,
    output logic             gt
);

    // Pure combinational ordering of the two chunks.
    always_comb begin
        lt = (a < b);
        gt = (a > b);
    end

endmodule

// File: rtl/dlx_set_cond_unit.sv
// Multi-cycle comparator for the DLX set-condition instructions.
// Operands are captured on START, scanned MSB-first DIGIT bits per cycle,
// and the scan stops at the first differing chunk. The 1-bit result is
// held on COMP_OUT until the next DONE pulse.
module dlx_set_cond_unit
    import dlx_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        SGN,
    input  logic [2:0]  COND,
    output logic        BUSY,
    output logic        DONE,
    output logic        COMP_OUT
);

    localparam int CHUNKS = 32 / DIGIT;
    localparam int IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    state_t            state_q, state_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic [2:0]        cond_q, cond_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              comp_q, comp_d;
    logic              done_q, done_d;

    logic [4:0]        bit_off;
    logic [DIGIT-1:0]  a_chunk;
    logic [DIGIT-1:0]  b_chunk;
    logic              c_lt;
    logic              c_gt;

    // Select the chunk addressed by the current scan index.
    always_comb begin
        bit_off = 5'(int'(idx_q) * DIGIT);
        a_chunk = a_q[bit_off +: DIGIT];
        b_chunk = b_q[bit_off +: DIGIT];
    end

    dlx_chunk_cmp #(
        .DIGIT (DIGIT)
    ) u_chunk_cmp (
        .a  (a_chunk),
        .b  (b_chunk),
        .lt (c_lt),
        .gt (c_gt)
    );

    // Next-state logic: capture on START in IDLE, scan one chunk per cycle in RUN.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis would infer a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cond_d  = cond_q;
        idx_d   = idx_q;
        comp_d  = comp_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (START) begin
                    // Flipping the sign bit of both operands turns a two's
                    // complement ordering into an unsigned one.
                    a_d     = {A[31] ^ SGN, A[30:0]};
                    b_d     = {B[31] ^ SGN, B[30:0]};
                    cond_d  = COND;
                    idx_d   = IDX_W'(CHUNKS - 1);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (c_lt || c_gt || (idx_q == '0)) begin
                    comp_d  = eval_cond(cond_q, c_lt, c_gt);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset; a reset mid-scan drops the run.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments make every register update from the
        // values seen before the edge, independent of statement order.
        if (RESET) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cond_q  <= COND_SEQ;
            idx_q   <= '0;
            comp_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cond_q  <= cond_d;
            idx_q   <= idx_d;
            comp_q  <= comp_d;
            done_q  <= done_d;
        end
    end

    // Outputs come straight from registers; DONE is only set when leaving RUN,
    // so it can never coincide with BUSY.
    always_comb begin
        BUSY     = (state_q == RUN);
        DONE     = done_q;
        COMP_OUT = comp_q;
    end

endmodule

// File: tb/tb_dlx_set_cond_unit.sv
// Self-checking bench for dlx_set_cond_unit: directed cases followed by
// random operations, compared against a plain-arithmetic reference model.
module tb_dlx_set_cond_unit;

    localparam int DIGIT  = 4;
    localparam int CHUNKS = 32 / DIGIT;

    logic        CLK;
    logic        RESET;
    logic        START;
    logic [31:0] A;
    logic [31:0] B;
    logic        SGN;
    logic [2:0]  COND;
    logic        BUSY;
    logic        DONE;
    logic        COMP_OUT;

    int   n_checks;
    int   n_errors;
    logic exp_prev;

    dlx_set_cond_unit #(
        .DIGIT (DIGIT)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .START    (START),
        .A        (A),
        .B        (B),
        .SGN      (SGN),
        .COND     (COND),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .COMP_OUT (COMP_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Result of the condition, straight from integer comparison.
    function automatic logic model_res(input logic [31:0] a, input logic [31:0] b,
                                       input logic sgn, input logic [2:0] cond);
        logic lt, gt, eq;
        if (sgn) begin
            lt = ($signed(a) < $signed(b));
            gt = ($signed(a) > $signed(b));
        end else begin
            lt = (a < b);
            gt = (a > b);
        end
        eq = (a == b);
        case (cond)
            3'd0:    return eq;
            3'd1:    return !eq;
            3'd2:    return lt;
            3'd3:    return gt;
            3'd4:    return lt || eq;
            3'd5:    return gt || eq;
            3'd6:    return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    // Number of compare edges: position of the highest differing bit decides
    // which chunk ends the scan; identical operands scan all chunks.
    function automatic int model_k(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x;
        x = a ^ b;
        if (x == 32'd0) return CHUNKS;
        for (int i = 31; i >= 0; i--) begin
            if (x[i]) return CHUNKS - (i / DIGIT);
        end
        return CHUNKS;
    endfunction

    // One full operation: START in the cycle after the previous DONE edge,
    // scramble inputs after capture, optionally pulse START while busy.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input logic [2:0] cond, input bit poke, input string tag);
        logic exp_res;
        int   exp_k;
        bit   got;
        int   k;
        logic res;
        bit   overlap;
        bit   hold_bad;

        exp_res  = model_res(a, b, sgn, cond);
        exp_k    = model_k(a, b);
        got      = 0;
        k        = 0;
        res      = 1'bx;
        overlap  = 0;
        hold_bad = 0;

        @(negedge CLK);
        START = 1'b1; A = a; B = b; SGN = sgn; COND = cond;
        @(posedge CLK); #1;
        START = 1'b0; A = $urandom; B = $urandom; SGN = ~sgn; COND = ~cond;

        for (int i = 1; i <= 40 && !got; i++) begin
            @(posedge CLK); #1;
            if (poke && i == 3) START = 1'b0;
            if (DONE && BUSY) overlap = 1;
            if (DONE) begin
                got = 1;
                k   = i;
                res = COMP_OUT;
            end else if (BUSY !== 1'b1 || COMP_OUT !== exp_prev) begin
                hold_bad = 1;
            end
            if (poke && i == 2 && !got) begin
                START = 1'b1; A = ~a; B = a; SGN = ~sgn; COND = ~cond;
            end
        end
        START = 1'b0;

        check({tag, "_done_seen"}, 32'(got), 32'd1);
        check({tag, "_latency"}, 32'(k), 32'(exp_k));
        check({tag, "_result"}, 32'(res), 32'(exp_res));
        check({tag, "_busy_hold"}, 32'(hold_bad), 32'd0);
        check({tag, "_done_busy_overlap"}, 32'(overlap), 32'd0);
        exp_prev = exp_res;
    endtask

    initial begin
        bit          saw_done;
        logic [31:0] ra, rb;

        n_checks = 0;
        n_errors = 0;
        exp_prev = 1'b0;
        RESET = 1'b1; START = 1'b0; A = '0; B = '0; SGN = 1'b0; COND = 3'd0;

        // Reset held for two edges, then released.
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        check("reset_busy", 32'(BUSY), 32'd0);
        check("reset_done", 32'(DONE), 32'd0);
        check("reset_comp", 32'(COMP_OUT), 32'd0);

        // Full-length scans with identical operands; the START pulse during
        // the first one must be ignored.
        do_op(32'h12345678, 32'h12345678, 1'b0, 3'd0, 1'b1, "eq_seq_poke");
        do_op(32'h12345678, 32'h12345678, 1'b0, 3'd1, 1'b0, "eq_sne");

        // Early exit on the top chunk, unsigned then signed.
        do_op(32'hF0000000, 32'h00000000, 1'b0, 3'd3, 1'b0, "early_sgt_u");
        do_op(32'hF0000000, 32'h00000000, 1'b1, 3'd3, 1'b0, "early_sgt_s");

        // -1 versus 1 under both interpretations.
        do_op(32'hFFFFFFFF, 32'h00000001, 1'b1, 3'd2, 1'b0, "slt_s");
        do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 3'd2, 1'b0, "slt_u");
        do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 3'd5, 1'b0, "sge_u");

        // Difference only in the lowest chunk.
        do_op(32'h00000010, 32'h00000011, 1'b0, 3'd4, 1'b0, "late_sle");

        // Back-to-back: accepted in the DONE cycle of the previous run.
        do_op(32'd5, 32'd5, 1'b0, 3'd0, 1'b0, "b2b_seq");

        // Constant conditions still scan.
        do_op(32'h00F00000, 32'h00E00000, 1'b0, 3'd6, 1'b0, "cond_false");
        do_op(32'h00F00000, 32'h00E00000, 1'b1, 3'd7, 1'b0, "cond_true");

        // Random operations, biased so that shared prefixes are common.
        for (int n = 0; n < 30; n++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = (ra & 32'hFFFF0000) | (rb & 32'h0000FFFF);
                2: rb = ra ^ (32'd1 << $urandom_range(0, 31));
                default: ;
            endcase
            do_op(ra, rb, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  bit'(n % 5 == 0), $sformatf("rnd%0d", n));
        end

        // Make sure COMP_OUT is 1 before the aborted run so its reset shows.
        do_op(32'd7, 32'd7, 1'b0, 3'd0, 1'b0, "pre_abort");

        // Reset three edges into a full-length run: no DONE afterwards.
        @(negedge CLK);
        START = 1'b1; A = 32'h12345678; B = 32'h12345678; SGN = 1'b0; COND = 3'd0;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b1;
        @(posedge CLK); #1;
        check("abort_busy", 32'(BUSY), 32'd0);
        check("abort_done", 32'(DONE), 32'd0);
        check("abort_comp", 32'(COMP_OUT), 32'd0);
        RESET = 1'b0;
        saw_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK); #1;
            if (DONE || BUSY) saw_done = 1;
        end
        check("abort_no_done", 32'(saw_done), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
